// File: rtl/draw_scheduler_pkg.sv
// Shared definitions for the draw scheduler and the shape drawer: FSM state
// encoding and the default coordinate/colour widths both blocks agree on.
package draw_scheduler_pkg;

  localparam int DEF_X_W  = 8;
  localparam int DEF_Y_W  = 7;
  localparam int COLOUR_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_ISSUE      = 2'd1,
    ST_WAIT_START = 2'd2,
    ST_WAIT_DONE  = 2'd3
  } sched_state_e;

  // States in which the scheduler is waiting on the drawer.
  function automatic logic is_waiting(input sched_state_e s);
    return (s == ST_WAIT_START) || (s == ST_WAIT_DONE);
  endfunction

endpackage

// File: rtl/draw_scheduler_if.sv
// Request/drawer bundle of the draw scheduler. The master side is the
// environment (game logic plus shape drawer); the slave side is the scheduler.
interface draw_scheduler_if
  import draw_scheduler_pkg::*;
#(
  parameter int X_W = DEF_X_W,
  parameter int Y_W = DEF_Y_W
);

  logic                reqValid;
  logic [X_W-1:0]      reqX;
  logic [Y_W-1:0]      reqY;
  logic [COLOUR_W-1:0] reqColour;
  logic                reqReady;

  logic                startingAddressLoaded;
  logic [X_W-1:0]      startX;
  logic [Y_W-1:0]      startY;
  logic [COLOUR_W-1:0] colour;
  logic                shapeDone;

  logic                busy;
  logic [7:0]          drawCount;
  logic                timeoutError;

  modport master (
    output reqValid, reqX, reqY, reqColour, shapeDone,
    input  reqReady, startingAddressLoaded, startX, startY, colour,
           busy, drawCount, timeoutError
  );

  modport slave (
    input  reqValid, reqX, reqY, reqColour, shapeDone,
    output reqReady, startingAddressLoaded, startX, startY, colour,
           busy, drawCount, timeoutError
  );

endinterface

// File: rtl/draw_req_fifo.sv
// Request queue for the draw scheduler: power-of-two circular buffer with a
// live count. A push while full is dropped even if a pop happens that edge.
module draw_req_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 18
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [W-1:0]             wdata_i,
  output logic [W-1:0]             rdata_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // NOTE: storage is deliberately not reset; an entry is only read after it
  // has been written, so clearing it would add reset fan-out for nothing.
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/draw_scheduler.sv
// Draw scheduler: queues shape requests and hands them one at a time to the
// shape drawer. Optional drawer watchdog enabled by macro DRAW_TIMEOUT_EN.
module draw_scheduler
  import draw_scheduler_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int X_W            = DEF_X_W,
  parameter int Y_W            = DEF_Y_W,
  parameter int TIMEOUT_CYCLES = 8192
) (
  input  logic            clock,
  input  logic            reset,
  draw_scheduler_if.slave bus
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int ENTRY_W = X_W + Y_W + COLOUR_W;

  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("draw_scheduler: FIFO_DEPTH must be a power of two in 2..16");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("draw_scheduler: TIMEOUT_CYCLES must be at least 1");
  end

  typedef struct packed {
    logic [X_W-1:0]      x;
    logic [Y_W-1:0]      y;
    logic [COLOUR_W-1:0] colour;
  } entry_t;

  entry_t           wr_entry, head;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_full, fifo_empty, fifo_push, fifo_pop;

  sched_state_e state_q, state_d;
  entry_t       start_q, start_d;
  logic [7:0]   draw_cnt_q, draw_cnt_d;
  logic         load_head;

  assign wr_entry  = '{x: bus.reqX, y: bus.reqY, colour: bus.reqColour};
  assign fifo_push = bus.reqValid && !fifo_full;

  draw_req_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (ENTRY_W)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .wdata_i (wr_entry),
    .rdata_o (head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  logic wd_expired;

`ifdef DRAW_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
  logic            timeout_q, timeout_d;

  // Counter holds the number of edges already spent waiting on the drawer.
  assign wd_expired = is_waiting(state_q) && (wd_cnt_q == WD_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    wd_cnt_d  = is_waiting(state_q) ? wd_cnt_q + 1'b1 : '0;
    timeout_d = timeout_q | wd_expired;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wd_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_cnt_q  <= wd_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.timeoutError = timeout_q;
`else
  assign wd_expired       = 1'b0;
  assign bus.timeoutError = 1'b0;
`endif

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    load_head  = 1'b0;
    fifo_pop   = 1'b0;
    draw_cnt_d = draw_cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty && bus.shapeDone) begin
          state_d   = ST_ISSUE;
          load_head = 1'b1;
        end
      end
      ST_ISSUE:      state_d = ST_WAIT_START;
      ST_WAIT_START: if (!bus.shapeDone) state_d = ST_WAIT_DONE;
      ST_WAIT_DONE: begin
        if (bus.shapeDone) begin
          state_d    = ST_IDLE;
          fifo_pop   = 1'b1;
          draw_cnt_d = draw_cnt_q + 8'd1;
        end
      end
    endcase
    // An expired watchdog abandons the shape: drop it but do not count it.
    if (wd_expired) begin
      state_d    = ST_IDLE;
      fifo_pop   = 1'b1;
      draw_cnt_d = draw_cnt_q;
    end
  end

  assign start_d = load_head ? head : start_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      start_q    <= '0;
      draw_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      start_q    <= start_d;
      draw_cnt_q <= draw_cnt_d;
    end
  end

  assign bus.reqReady              = (fifo_count < CNT_W'(FIFO_DEPTH));
  assign bus.startingAddressLoaded = (state_q == ST_ISSUE);
  assign bus.startX                = start_q.x;
  assign bus.startY                = start_q.y;
  assign bus.colour                = start_q.colour;
  assign bus.busy                  = (state_q != ST_IDLE);
  assign bus.drawCount             = draw_cnt_q;

endmodule

// File: tb/tb_draw_scheduler.sv
// Directed self-checking bench for draw_scheduler; the watchdog scenario
// switches behaviour with DRAW_TIMEOUT_EN.
module tb_draw_scheduler;
  import draw_scheduler_pkg::*;

  localparam int FIFO_DEPTH     = 4;
  localparam int X_W            = 8;
  localparam int Y_W            = 7;
  localparam int TIMEOUT_CYCLES = 16;

  logic clock = 1'b0;
  logic reset = 1'b1;

  draw_scheduler_if #(.X_W(X_W), .Y_W(Y_W)) bus ();

  draw_scheduler #(
    .FIFO_DEPTH     (FIFO_DEPTH),
    .X_W            (X_W),
    .Y_W            (Y_W),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int n_tests   = 0;
  int n_fail    = 0;
  int exp_draws = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [7:0] x, input logic [6:0] y, input logic [2:0] c);
    bus.reqValid  = 1'b1;
    bus.reqX      = x;
    bus.reqY      = y;
    bus.reqColour = c;
    tick();
    bus.reqValid  = 1'b0;
  endtask

  task automatic wait_pulse(input string tag);
    for (int i = 0; i < 20 && !bus.startingAddressLoaded; i++) tick();
    check({tag, " pulse"}, 32'(bus.startingAddressLoaded), 32'd1);
  endtask

  // Drawer model: goes busy, stays busy a cycle, then returns idle.
  task automatic finish_draw();
    bus.shapeDone = 1'b0;
    tick();
    tick();
    bus.shapeDone = 1'b1;
    tick();
    exp_draws = (exp_draws + 1) % 256;
  endtask

  task automatic do_draw(input string tag, input logic [7:0] x, input logic [6:0] y, input logic [2:0] c);
    wait_pulse(tag);
    check({tag, " startX"}, 32'(bus.startX), 32'(x));
    check({tag, " startY"}, 32'(bus.startY), 32'(y));
    check({tag, " colour"}, 32'(bus.colour), 32'(c));
    finish_draw();
    check({tag, " drawCount"}, 32'(bus.drawCount), 32'(exp_draws));
  endtask

  task automatic expect_no_pulse(input string tag, input int cycles);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      seen = seen | bus.startingAddressLoaded;
    end
    check(tag, 32'(seen), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish, got hang, expected completion");
    $fatal(1);
  end

  initial begin
    logic [7:0] xs [5];
    logic [6:0] ys [5];
    logic [2:0] cs [5];
    logic       missed;

    xs = '{8'd11, 8'd22, 8'd33, 8'd44, 8'd55};
    ys = '{7'd1, 7'd2, 7'd3, 7'd4, 7'd5};
    cs = '{3'd1, 3'd2, 3'd4, 3'd6, 3'd7};

    bus.reqValid  = 1'b0;
    bus.reqX      = '0;
    bus.reqY      = '0;
    bus.reqColour = '0;
    bus.shapeDone = 1'b1;

    // Reset state
    reset = 1'b1;
    tick();
    tick();
    check("rst pulse", 32'(bus.startingAddressLoaded), 32'd0);
    check("rst busy", 32'(bus.busy), 32'd0);
    check("rst startX", 32'(bus.startX), 32'd0);
    check("rst drawCount", 32'(bus.drawCount), 32'd0);
    check("rst timeoutError", 32'(bus.timeoutError), 32'd0);
    reset = 1'b0;
    tick();
    check("rst reqReady", 32'(bus.reqReady), 32'd1);

    // Single request, latency: accepted at E0, pulse only during E1..E2
    push(8'd10, 7'd20, 3'd3);
    check("t1 E0 pulse", 32'(bus.startingAddressLoaded), 32'd0);
    tick();
    check("t1 E1 pulse", 32'(bus.startingAddressLoaded), 32'd1);
    check("t1 E1 busy", 32'(bus.busy), 32'd1);
    check("t1 startX", 32'(bus.startX), 32'd10);
    check("t1 startY", 32'(bus.startY), 32'd20);
    check("t1 colour", 32'(bus.colour), 32'd3);
    tick();
    check("t1 E2 pulse", 32'(bus.startingAddressLoaded), 32'd0);
    finish_draw();
    check("t1 drawCount", 32'(bus.drawCount), 32'd1);
    check("t1 idle", 32'(bus.busy), 32'd0);
    check("t1 startX held", 32'(bus.startX), 32'd10);
    expect_no_pulse("t1 no extra pulse", 4);

    // Five back-to-back requests with the drawer stalled; the fifth is dropped
    bus.shapeDone = 1'b0;
    for (int k = 0; k < 5; k++) begin
      bus.reqValid  = 1'b1;
      bus.reqX      = xs[k];
      bus.reqY      = ys[k];
      bus.reqColour = cs[k];
      check($sformatf("t2 reqReady before push %0d", k), 32'(bus.reqReady), (k < 4) ? 32'd1 : 32'd0);
      tick();
    end
    bus.reqValid = 1'b0;
    check("t2 full reqReady", 32'(bus.reqReady), 32'd0);
    check("t2 stalled busy", 32'(bus.busy), 32'd0);
    bus.shapeDone = 1'b1;
    for (int k = 0; k < 4; k++) do_draw($sformatf("t2 draw %0d", k), xs[k], ys[k], cs[k]);
    expect_no_pulse("t2 fifth dropped", 5);

    // Push and pop on the same edge with two entries queued
    bus.shapeDone = 1'b0;
    push(8'd101, 7'd11, 3'd1);
    push(8'd102, 7'd12, 3'd2);
    bus.shapeDone = 1'b1;
    wait_pulse("t3 A");
    check("t3 A startX", 32'(bus.startX), 32'd101);
    tick();
    bus.shapeDone = 1'b0;
    tick();
    bus.shapeDone = 1'b1;
    push(8'd103, 7'd13, 3'd3);
    exp_draws++;
    check("t3 pop+push drawCount", 32'(bus.drawCount), 32'(exp_draws));
    push(8'd104, 7'd14, 3'd4);
    push(8'd105, 7'd15, 3'd5);
    check("t3 count 4 reqReady", 32'(bus.reqReady), 32'd0);
    check("t3 B startX", 32'(bus.startX), 32'd102);
    check("t3 B colour", 32'(bus.colour), 32'd2);
    finish_draw();
    do_draw("t3 C", 8'd103, 7'd13, 3'd3);
    do_draw("t3 D", 8'd104, 7'd14, 3'd4);
    do_draw("t3 E", 8'd105, 7'd15, 3'd5);
    expect_no_pulse("t3 drained", 4);

    // Drawer stuck busy
    push(8'd77, 7'd7, 3'd7);
    wait_pulse("t6");
    tick();
    bus.shapeDone = 1'b0;
    for (int i = 0; i < TIMEOUT_CYCLES - 1; i++) tick();
    check("t6 busy before limit", 32'(bus.busy), 32'd1);
    tick();
`ifdef DRAW_TIMEOUT_EN
    check("t6 forced idle", 32'(bus.busy), 32'd0);
    check("t6 timeoutError", 32'(bus.timeoutError), 32'd1);
    check("t6 drawCount kept", 32'(bus.drawCount), 32'(exp_draws));
    bus.shapeDone = 1'b1;
    expect_no_pulse("t6 head popped", 4);
    check("t6 timeoutError sticky", 32'(bus.timeoutError), 32'd1);
`else
    check("t6 still waiting", 32'(bus.busy), 32'd1);
    check("t6 timeoutError tied", 32'(bus.timeoutError), 32'd0);
    bus.shapeDone = 1'b1;
    tick();
    exp_draws++;
    check("t6 late finish", 32'(bus.drawCount), 32'(exp_draws));
`endif

    // Reset in WAIT_DONE with three queued
    bus.shapeDone = 1'b0;
    push(8'd1, 7'd1, 3'd1);
    push(8'd2, 7'd2, 3'd2);
    push(8'd3, 7'd3, 3'd3);
    bus.shapeDone = 1'b1;
    wait_pulse("t4");
    tick();
    bus.shapeDone = 1'b0;
    tick();
    check("t4 in WAIT_DONE", 32'(bus.busy), 32'd1);
    reset = 1'b1;
    tick();
    check("t4 rst pulse", 32'(bus.startingAddressLoaded), 32'd0);
    check("t4 rst busy", 32'(bus.busy), 32'd0);
    check("t4 rst startX", 32'(bus.startX), 32'd0);
    check("t4 rst startY", 32'(bus.startY), 32'd0);
    check("t4 rst colour", 32'(bus.colour), 32'd0);
    check("t4 rst drawCount", 32'(bus.drawCount), 32'd0);
    check("t4 rst timeoutError", 32'(bus.timeoutError), 32'd0);
    reset = 1'b0;
    bus.shapeDone = 1'b1;
    exp_draws = 0;
    tick();
    check("t4 reqReady", 32'(bus.reqReady), 32'd1);
    expect_no_pulse("t4 queue flushed", 10);
    check("t4 drawCount", 32'(bus.drawCount), 32'd0);

    // drawCount wraps 255 -> 0
    missed = 1'b0;
    for (int i = 0; i < 255; i++) begin
      push(8'(i), 7'd0, 3'd0);
      for (int j = 0; j < 20 && !bus.startingAddressLoaded; j++) tick();
      missed = missed | !bus.startingAddressLoaded;
      finish_draw();
    end
    check("t5 no missed issue", 32'(missed), 32'd0);
    check("t5 drawCount 255", 32'(bus.drawCount), 32'd255);
    push(8'd200, 7'd100, 3'd5);
    do_draw("t5 wrap", 8'd200, 7'd100, 3'd5);
    check("t5 drawCount 0", 32'(bus.drawCount), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/draw_scheduler.md
DRAW_SCHEDULER -- requirements
Module: draw_scheduler

Interface
REQ-001 Parameter FIFO_DEPTH, 4, request queue entries (power of two, 2..16).
REQ-002 Parameter X_W, 8, start-X width.
REQ-003 Parameter Y_W, 7, start-Y width.
REQ-004 Parameter TIMEOUT_CYCLES, 8192, drawer watchdog limit (used only with DRAW_TIMEOUT_EN).
REQ-005 Port clock  in  1  single clock; all state changes on rising edge.
REQ-006 Port reset  in  1  synchronous, active-high reset.
REQ-007 Port reqValid  in  1  game logic offers a shape draw request.
REQ-008 Port reqX  in  X_W  requested top-left X.
REQ-009 Port reqY  in  Y_W  requested top-left Y.
REQ-010 Port reqColour  in  3  requested colour.
REQ-011 Port reqReady  out  1  queue can accept; equals (count < FIFO_DEPTH).
REQ-012 Port startingAddressLoaded  out  1  one-cycle start pulse to shape drawer.
REQ-013 Port startX / startY / colour  out  X_W / Y_W / 3  head-of-queue coordinates and colour presented to drawer.
REQ-014 Port shapeDone  in  1  drawer idle indication (high while drawer idle).
REQ-015 Port busy  out  1  high in any state except IDLE.
REQ-016 Port drawCount  out  8  completed shapes, wraps 255->0.
REQ-017 Port timeoutError  out  1  sticky watchdog flag (constant 0 without DRAW_TIMEOUT_EN).

Function
REQ-018 Request accepted on an edge where reqValid && reqReady; entry written at write pointer, count+1.
REQ-019 Push and pop on the same edge leave count unchanged; push while full is dropped even if a pop occurs that edge.
REQ-020 FSM states: IDLE, ISSUE, WAIT_START, WAIT_DONE.
REQ-021 IDLE -> ISSUE when count != 0 && shapeDone; else hold.
REQ-022 ISSUE -> WAIT_START unconditionally; startingAddressLoaded high only in ISSUE (exactly one cycle).
REQ-023 WAIT_START -> WAIT_DONE when shapeDone low; else hold.
REQ-024 WAIT_DONE -> IDLE when shapeDone high; that edge pops the head entry and increments drawCount.
REQ-025 startX/startY/colour registered from head entry on entry to ISSUE and held stable until return to IDLE.
REQ-026 Latency: request accepted at edge E0 into empty queue with drawer idle -> ISSUE at E1, pulse high E1..E2.
REQ-027 Back-to-back: next ISSUE no earlier than one cycle after WAIT_DONE -> IDLE.
REQ-028 Pointers wrap modulo FIFO_DEPTH; count width clog2(FIFO_DEPTH)+1.

Reset
REQ-029 Reset on any edge, in any state: FSM IDLE, count/pointers 0, startingAddressLoaded 0, startX/startY/colour 0, drawCount 0, timeoutError 0, busy 0; reqReady 1 the cycle after reset.
REQ-030 Reset mid-draw discards the in-flight and all queued requests; no pop, no drawCount increment.

Configuration
REQ-031 Macro DRAW_TIMEOUT_EN defined: cycle counter cleared in IDLE, counts in WAIT_START/WAIT_DONE; reaching TIMEOUT_CYCLES forces IDLE, pops head, sets timeoutError until reset, no drawCount increment.
REQ-032 Macro undefined: no watchdog counter, WAIT states wait indefinitely, timeoutError tied 0.

Structure
REQ-033 Shared package holds FSM state encoding constants and default X_W/Y_W/colour widths shared with the shape drawer.
REQ-034 Queue is sub-module draw_req_fifo (push/pop/count/full/empty); FSM and counters in draw_scheduler.

Verification
REQ-035 Reset, one request (X=10,Y=20,colour=3), drawer model idle -> pulse at E1 only, startX=10/startY=20, drawCount=1 after shapeDone returns.
REQ-036 Five requests pushed back-to-back, drawer stalled -> reqReady low after 4 accepted, 5th dropped, later four draws in FIFO order.
REQ-037 Push and pop same edge at count=2 -> count stays 2, data order preserved.
REQ-038 Reset asserted during WAIT_DONE with 3 queued -> all outputs reset values, no further pulses, drawCount 0.
REQ-039 DRAW_TIMEOUT_EN, TIMEOUT_CYCLES=16, shapeDone stuck low -> IDLE after 16 cycles, timeoutError=1 held, drawCount unchanged.
REQ-040 drawCount at 255 after one more completed draw -> 0.
